// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded T-state control unit for the 8-bit bus CPU
//
// Steps through fetch (T0,T1) and per-opcode execute states (T2..T4) and
// decodes the bus enable / load / step strobes for the datapath.
//
// Ports:
//   clk, rst            - clock (advance on rising edge), async active-high reset
//   opcode              - instruction register upper nibble
//   carry_flag,zero_flag- latched flags used by JC / JZ
//   step                - current T-state (debug/display)
//   halted              - set by HLT, cleared only by rst
//   pc_*, mar_ie, ram_*, ir_*, a_*, b_ie, alu_*, flags_ie, out_ie
//                       - datapath strobes, combinational from state/opcode/flags
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int NUM_STEPS    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    carry_flag,
    input  logic                    zero_flag,
    output logic [2:0]              step,
    output logic                    halted,
    output logic                    pc_oe,
    output logic                    pc_ie,
    output logic                    pc_step,
    output logic                    mar_ie,
    output logic                    ram_oe,
    output logic                    ram_ie,
    output logic                    ir_oe,
    output logic                    ir_ie,
    output logic                    a_oe,
    output logic                    a_ie,
    output logic                    b_ie,
    output logic                    alu_oe,
    output logic                    alu_sub,
    output logic                    flags_ie,
    output logic                    out_ie
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } t_state;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

    // Highest legal T-state; anything at or beyond it wraps to T0.
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    t_state r_step;
    logic   r_halted;
    t_state w_last;

    assign step   = r_step;
    assign halted = r_halted;

    // Final T-state of the current instruction. NOP, undefined opcodes and
    // all single-execute-cycle instructions finish in T2.
    always_comb begin
        w_last = T2;
        case (opcode)
            OP_LDA, OP_STA: w_last = T3;
            OP_ADD, OP_SUB: w_last = T4;
            default:        w_last = T2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (r_step == T2 && opcode == OP_HLT) begin
                // Step stays at T2 while halted.
                r_halted <= 1'b1;
            end else if (r_step >= w_last || r_step >= LAST_STEP) begin
                r_step <= T0;
            end else begin
                r_step <= t_state'(r_step + 3'd1);
            end
        end
    end

    // Strobes are held low during reset and while halted, so they drop
    // immediately on an asynchronous reset without waiting for a clock.
    always_comb begin
        pc_oe    = 1'b0;
        pc_ie    = 1'b0;
        pc_step  = 1'b0;
        mar_ie   = 1'b0;
        ram_oe   = 1'b0;
        ram_ie   = 1'b0;
        ir_oe    = 1'b0;
        ir_ie    = 1'b0;
        a_oe     = 1'b0;
        a_ie     = 1'b0;
        b_ie     = 1'b0;
        alu_oe   = 1'b0;
        alu_sub  = 1'b0;
        flags_ie = 1'b0;
        out_ie   = 1'b0;
        if (!rst && !r_halted) begin
            case (r_step)
                T0: begin
                    pc_oe  = 1'b1;
                    mar_ie = 1'b1;
                end
                T1: begin
                    ram_oe  = 1'b1;
                    ir_ie   = 1'b1;
                    pc_step = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_oe  = 1'b1;
                            mar_ie = 1'b1;
                        end
                        OP_LDI: begin
                            ir_oe = 1'b1;
                            a_ie  = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe = 1'b1;
                            pc_ie = 1'b1;
                        end
                        // Flags are read live so a same-cycle update is honoured.
                        OP_JC: begin
                            ir_oe = carry_flag;
                            pc_ie = carry_flag;
                        end
                        OP_JZ: begin
                            ir_oe = zero_flag;
                            pc_ie = zero_flag;
                        end
                        OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ie = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_ie   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_ie   = 1'b1;
                        end
                        OP_STA: begin
                            a_oe   = 1'b1;
                            ram_ie = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe   = 1'b1;
                        a_ie     = 1'b1;
                        flags_ie = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    logic [2:0] step;
    logic       halted;
    logic pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_oe, ir_ie;
    logic a_oe, a_ie, b_ie, alu_oe, alu_sub, flags_ie, out_ie;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [14:0] PC_OE    = 15'h4000;
    localparam logic [14:0] PC_IE    = 15'h2000;
    localparam logic [14:0] PC_STEP  = 15'h1000;
    localparam logic [14:0] MAR_IE   = 15'h0800;
    localparam logic [14:0] RAM_OE   = 15'h0400;
    localparam logic [14:0] RAM_IE   = 15'h0200;
    localparam logic [14:0] IR_OE    = 15'h0100;
    localparam logic [14:0] IR_IE    = 15'h0080;
    localparam logic [14:0] A_OE     = 15'h0040;
    localparam logic [14:0] A_IE     = 15'h0020;
    localparam logic [14:0] B_IE     = 15'h0010;
    localparam logic [14:0] ALU_OE   = 15'h0008;
    localparam logic [14:0] ALU_SUB  = 15'h0004;
    localparam logic [14:0] FLAGS_IE = 15'h0002;
    localparam logic [14:0] OUT_IE   = 15'h0001;

    localparam logic [14:0] C_T0 = PC_OE | MAR_IE;
    localparam logic [14:0] C_T1 = RAM_OE | IR_IE | PC_STEP;
    localparam logic [14:0] C_NONE = 15'h0000;

    logic [14:0] ctrl;
    assign ctrl = {pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_oe, ir_ie,
                   a_oe, a_ie, b_ie, alu_oe, alu_sub, flags_ie, out_ie};

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .step       (step),
        .halted     (halted),
        .pc_oe      (pc_oe),
        .pc_ie      (pc_ie),
        .pc_step    (pc_step),
        .mar_ie     (mar_ie),
        .ram_oe     (ram_oe),
        .ram_ie     (ram_ie),
        .ir_oe      (ir_oe),
        .ir_ie      (ir_ie),
        .a_oe       (a_oe),
        .a_ie       (a_ie),
        .b_ie       (b_ie),
        .alu_oe     (alu_oe),
        .alu_sub    (alu_sub),
        .flags_ie   (flags_ie),
        .out_ie     (out_ie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check state and strobes now, without waiting.
    task automatic chk_now(input string tag, input logic [2:0] s, input logic [14:0] c);
        check({tag, ".step"}, 32'(step), 32'(s));
        check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    endtask

    // Advance to the next falling edge and check that cycle.
    task automatic cyc(input string tag, input logic [2:0] s, input logic [14:0] c);
        @(negedge clk);
        chk_now(tag, s, c);
    endtask

    // Each instruction begins at T0; the opcode is changed only after the
    // T0 check so the previous instruction's final edge sees its own opcode.
    task automatic start(input string tag, input logic [3:0] op);
        cyc({tag, ".t0"}, 3'd0, C_T0);
        opcode = op;
        cyc({tag, ".t1"}, 3'd1, C_T1);
    endtask

    initial begin
        rst        = 1'b1;
        opcode     = 4'h0;
        carry_flag = 1'b0;
        zero_flag  = 1'b0;

        @(negedge clk);
        chk_now("rst", 3'd0, C_NONE);
        check("rst.halted", 32'(halted), 32'd0);
        @(negedge clk);
        chk_now("rst2", 3'd0, C_NONE);

        // Release: outputs reflect T0 before any rising edge.
        rst = 1'b0;
        #1 chk_now("nop.t0", 3'd0, C_T0);
        cyc("nop.t1", 3'd1, C_T1);
        cyc("nop.t2", 3'd2, C_NONE);
        cyc("nop2.t0", 3'd0, C_T0);
        cyc("nop2.t1", 3'd1, C_T1);
        cyc("nop2.t2", 3'd2, C_NONE);

        start("add", 4'h2);
        cyc("add.t2", 3'd2, IR_OE | MAR_IE);
        cyc("add.t3", 3'd3, RAM_OE | B_IE);
        cyc("add.t4", 3'd4, ALU_OE | A_IE | FLAGS_IE);

        start("sub", 4'h3);
        cyc("sub.t2", 3'd2, IR_OE | MAR_IE);
        cyc("sub.t3", 3'd3, RAM_OE | B_IE);
        cyc("sub.t4", 3'd4, ALU_OE | A_IE | FLAGS_IE | ALU_SUB);

        carry_flag = 1'b0;
        start("jc0", 4'h7);
        cyc("jc0.t2", 3'd2, C_NONE);

        carry_flag = 1'b1;
        start("jc1", 4'h7);
        cyc("jc1.t2", 3'd2, IR_OE | PC_IE);

        zero_flag = 1'b0;
        start("jz0", 4'h8);
        cyc("jz0.t2", 3'd2, C_NONE);

        zero_flag = 1'b1;
        start("jz1", 4'h8);
        cyc("jz1.t2", 3'd2, IR_OE | PC_IE);

        // Carry rises inside T2 itself and must still be honoured.
        carry_flag = 1'b0;
        start("jclate", 4'h7);
        @(posedge clk);
        #1 carry_flag = 1'b1;
        cyc("jclate.t2", 3'd2, IR_OE | PC_IE);

        start("lda", 4'h1);
        cyc("lda.t2", 3'd2, IR_OE | MAR_IE);
        cyc("lda.t3", 3'd3, RAM_OE | A_IE);

        start("sta", 4'h4);
        cyc("sta.t2", 3'd2, IR_OE | MAR_IE);
        cyc("sta.t3", 3'd3, A_OE | RAM_IE);

        start("ldi", 4'h5);
        cyc("ldi.t2", 3'd2, IR_OE | A_IE);

        start("jmp", 4'h6);
        cyc("jmp.t2", 3'd2, IR_OE | PC_IE);

        start("out", 4'hE);
        cyc("out.t2", 3'd2, A_OE | OUT_IE);

        start("undef", 4'hB);
        cyc("undef.t2", 3'd2, C_NONE);

        // Asynchronous reset in the middle of LDA's T3.
        start("ldar", 4'h1);
        cyc("ldar.t2", 3'd2, IR_OE | MAR_IE);
        cyc("ldar.t3", 3'd3, RAM_OE | A_IE);
        #2 rst = 1'b1;
        #1 chk_now("arst", 3'd0, C_NONE);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_now("arst.t0", 3'd0, C_T0);
        cyc("arst.t1", 3'd1, C_T1);
        cyc("arst.t2", 3'd2, IR_OE | MAR_IE);
        cyc("arst.t3", 3'd3, RAM_OE | A_IE);

        start("hlt", 4'hF);
        cyc("hlt.t2", 3'd2, C_NONE);
        check("hlt.t2.halted", 32'(halted), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc("halt", 3'd2, C_NONE);
            check("halt.halted", 32'(halted), 32'd1);
        end
        #1 rst = 1'b1;
        opcode = 4'h0;
        #1 chk_now("hrst", 3'd0, C_NONE);
        check("hrst.halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_now("hrst.t0", 3'd0, C_T0);

        // Random opcodes (HLT excluded) and flags: structural invariants.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("rnd.bus_onehot",
                  32'(int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe) <= 1), 32'd1);
            check("rnd.pc_ie_step", 32'(pc_ie & pc_step), 32'd0);
            check("rnd.step_max", 32'(step <= 3'd4), 32'd1);
            opcode     = 4'($urandom_range(0, 14));
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag  = 1'($urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit for the 8-bit bus CPU. It steps through fetch and execute T-states and drives the enable and step strobes of the program counter, memory address register, RAM, instruction register, A/B registers, ALU, flags and output register. It is the direct upstream driver of the program counter's ie/oe/step inputs. It consumes the opcode nibble from the instruction register and the carry/zero flags.

Parameters:
OPCODE_WIDTH, 4, width of opcode field (instr[7:4])
NUM_STEPS, 5, T-states T0..T4; step counter width is 3 bits

Ports:
clk  input  1  system clock; sequencer advances on rising edge, datapath latches on falling edge
rst  input  1  asynchronous, active-high reset
opcode  input  4  upper nibble of instruction register
carry_flag  input  1  latched carry from flags register
zero_flag  input  1  latched zero from flags register
step  output  3  current T-state, for debug/display
halted  output  1  high once HLT executed
pc_oe  output  1  program counter drives bus
pc_ie  output  1  program counter loads from bus
pc_step  output  1  program counter increments
mar_ie  output  1  MAR loads from bus
ram_oe  output  1  RAM drives bus
ram_ie  output  1  RAM writes from bus
ir_oe  output  1  IR drives operand nibble to bus
ir_ie  output  1  IR loads from bus
a_oe, a_ie  output  1 each  A register bus drive/load
b_ie  output  1  B register load
alu_oe  output  1  ALU result drives bus
alu_sub  output  1  ALU subtract select
flags_ie  output  1  flags register latch
out_ie  output  1  output register load

Behaviour:
- State: step[2:0], halted. Both update on rising clk only. Control outputs are combinational from (step, opcode, flags, halted, rst). They are stable across the following falling edge.
- Reset (async, rst=1): step=0, halted=0. Every control output is forced 0 while rst is high. After rst deasserts, outputs reflect T0.
- Fetch, common to all opcodes:
  - T0: pc_oe, mar_ie.
  - T1: ram_oe, ir_ie, pc_step.
- Execute by opcode. "end" means the next rising edge sets step to 0.
  - 0 NOP: T2 empty, end.
  - 1 LDA: T2 ir_oe+mar_ie; T3 ram_oe+a_ie, end.
  - 2 ADD: T2 ir_oe+mar_ie; T3 ram_oe+b_ie; T4 alu_oe+a_ie+flags_ie, end.
  - 3 SUB: as ADD, with alu_sub also high in T4.
  - 4 STA: T2 ir_oe+mar_ie; T3 a_oe+ram_ie, end.
  - 5 LDI: T2 ir_oe+a_ie, end.
  - 6 JMP: T2 ir_oe+pc_ie, end.
  - 7 JC: T2 ir_oe+pc_ie only if carry_flag=1, else empty; end either way.
  - 8 JZ: same as JC using zero_flag.
  - E OUT: T2 a_oe+out_ie, end.
  - F HLT: T2 no strobes; rising edge sets halted=1, step stays 2.
  - 9–D undefined: treated as NOP.
- Instruction length in cycles: NOP/LDI/JMP/JC/JZ/OUT = 3, LDA/STA = 4, ADD/SUB = 5.
- Flags are sampled combinationally during T2 of JC/JZ. A change in the same cycle that makes it to the falling edge is honoured.
- step never exceeds 4. If step reaches 4 on an opcode without a T4 entry, the next edge returns to 0 (defensive).
- Halted: all control outputs 0, step frozen. Only rst clears halted.
- Invariants:
  - At most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle.
  - pc_ie and pc_step are never both high.
- Reset mid-instruction: outputs drop to 0 immediately (asynchronous). Fetch restarts at T0 on the first rising edge after release (step already 0).

Test Plan:
- Reset release, opcode=0: step sequence 0,1,2,0,1. T0 pc_oe=mar_ie=1; T1 ram_oe=ir_ie=pc_step=1; T2 all strobes 0.
- opcode=2: 5-cycle loop. T4 has alu_oe=a_ie=flags_ie=1, alu_sub=0. Repeat with opcode=3: alu_sub=1 in T4 only.
- opcode=7: with carry_flag=0, T2 all strobes 0 and step returns to 0. With carry_flag=1, T2 ir_oe=pc_ie=1. Repeat for opcode=8 with zero_flag.
- opcode=F: after T2 edge, halted=1, step=2, all strobes 0 for 20 cycles. Pulse rst: halted=0, step=0.
- Assert rst asynchronously mid-T3 of opcode=1: outputs 0 before next clk edge. After release, first cycle is T0.
- Random opcodes and flags for 1000 cycles: one-hot-or-zero bus-drive assertion holds, pc_ie&pc_step never both 1, step ≤ 4.
